// File: rtl/cache_fill_pkg.sv
// Shared types and geometry for the instruction-cache line fill engine.
// A line is 8 words of 16 bits; word offsets are 3 bits wide.
package cache_fill_pkg;

    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 16;
    localparam int BLOCK_WORDS = 8;
    localparam int OFFSET_W    = 3;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        TAG  = 2'd2
    } fill_state_e;

    // Byte address -> address of the first byte of its 16-byte line.
    function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:4], 4'b0000};
    endfunction

endpackage

// File: rtl/fill_counter.sv
// Word counter for one direction of a line fill (requests issued or data received).
// Saturates at BLOCK_WORDS and raises done there.
module fill_counter
    import cache_fill_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    logic [CNT_W-1:0] count_r;
    logic             done_s;

    assign done_s = (count_r == CNT_W'(BLOCK_WORDS));

    // Count register: clear wins over increment, never counts past a full line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            count_r <= {CNT_W{1'b0}};
        end else if (inc && !done_s) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign done  = done_s;

endmodule

// File: rtl/cache_fill_fsm.sv
// Line fill controller: on a miss, streams 8 word reads to memory, writes each
// returned word into the data array, then updates the tag array in one cycle.
module cache_fill_fsm
    import cache_fill_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                miss_detected,
    input  logic [ADDR_W-1:0]   miss_address,
    input  logic [DATA_W-1:0]   mem_data,
    input  logic                mem_data_valid,
    output logic                mem_enable,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                data_write,
    output logic                tag_write,
    output logic [OFFSET_W-1:0] offset_write_fsm,
    output logic [DATA_W-1:0]   fill_data,
    output logic [ADDR_W-1:0]   fill_address,
    output logic                stall
);

    fill_state_e       state_r;
    fill_state_e       state_next_s;
    logic [ADDR_W-1:0] base_r;
    logic [CNT_W-1:0]  issue_cnt_s;
    logic [CNT_W-1:0]  recv_cnt_s;
    logic              issue_done_s;
    logic              recv_done_s;
    logic              issue_inc_s;
    logic              recv_inc_s;
    logic              cnt_clr_s;

    fill_counter u_issue_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr_s),
        .inc   (issue_inc_s),
        .count (issue_cnt_s),
        .done  (issue_done_s)
    );

    fill_counter u_recv_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr_s),
        .inc   (recv_inc_s),
        .count (recv_cnt_s),
        .done  (recv_done_s)
    );

    // Counter control: both counters run only in FILL and sit at zero otherwise,
    // so any response arriving outside an active fill is dropped.
    always_comb begin
        issue_inc_s = 1'b0;
        recv_inc_s  = 1'b0;
        cnt_clr_s   = 1'b1;
        if (state_r == FILL) begin
            issue_inc_s = !issue_done_s;
            recv_inc_s  = mem_data_valid && !recv_done_s;
            cnt_clr_s   = 1'b0;
        end else begin
            cnt_clr_s   = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Line base is captured only when a fill starts and held until the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_r <= {ADDR_W{1'b0}};
        end else if ((state_r == IDLE) && miss_detected) begin
            base_r <= block_base(miss_address);
        end else begin
            base_r <= base_r;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (miss_detected) begin
                    state_next_s = FILL;
                end else begin
                    state_next_s = IDLE;
                end
            end
            FILL: begin
                if (recv_inc_s && (recv_cnt_s == CNT_W'(BLOCK_WORDS - 1))) begin
                    state_next_s = TAG;
                end else begin
                    state_next_s = FILL;
                end
            end
            TAG:     state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Output decode; everything except fill_address is held low while rst is high.
    always_comb begin
        mem_enable       = 1'b0;
        mem_address      = {ADDR_W{1'b0}};
        data_write       = 1'b0;
        tag_write        = 1'b0;
        offset_write_fsm = {OFFSET_W{1'b0}};
        fill_data        = {DATA_W{1'b0}};
        stall            = 1'b0;
        if (state_r == IDLE) begin
            fill_address = block_base(miss_address);
        end else begin
            fill_address = base_r;
        end
        if (rst) begin
            stall = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    stall = miss_detected;
                end
                FILL: begin
                    stall      = 1'b1;
                    mem_enable = issue_inc_s;
                    if (issue_inc_s) begin
                        mem_address = base_r + {11'd0, issue_cnt_s, 1'b0};
                    end else begin
                        mem_address = {ADDR_W{1'b0}};
                    end
                    data_write = recv_inc_s;
                    if (recv_inc_s) begin
                        offset_write_fsm = recv_cnt_s[OFFSET_W-1:0];
                        fill_data        = mem_data;
                    end else begin
                        offset_write_fsm = {OFFSET_W{1'b0}};
                        fill_data        = {DATA_W{1'b0}};
                    end
                end
                TAG: begin
                    stall     = 1'b1;
                    tag_write = 1'b1;
                end
                default: begin
                    stall = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm: a memory model answers issued reads, the
// expected read addresses and data-array writes are queued and popped as the DUT acts.
module tb_cache_fill_fsm;

    localparam int S_IDLE = 0;
    localparam int S_FILL = 1;
    localparam int S_TAG  = 2;
    localparam int LAT    = 3;  // data appears in the 4th cycle counting the issue cycle

    typedef struct {
        int          ready;
        logic [15:0] data;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic [15:0] mem_data;
    logic        mem_data_valid;
    logic        mem_enable;
    logic [15:0] mem_address;
    logic        data_write;
    logic        tag_write;
    logic [2:0]  offset_write_fsm;
    logic [15:0] fill_data;
    logic [15:0] fill_address;
    logic        stall;

    int          n_cmp = 0;
    int          n_mis = 0;
    int          cyc = 0;
    int          m_state = S_IDLE;
    logic [15:0] m_base = 16'h0000;
    bit          accepting = 1'b0;
    int          words_rx = 0;
    int          issued = 0;
    int          stall_cnt = 0;
    int          last_ready = -100;
    bit          gap_mode = 1'b0;
    resp_t       mem_q[$];
    logic [15:0] exp_rd_q[$];
    logic [18:0] exp_wr_q[$];

    cache_fill_fsm dut (
        .clk              (clk),
        .rst              (rst),
        .miss_detected    (miss_detected),
        .miss_address     (miss_address),
        .mem_data         (mem_data),
        .mem_data_valid   (mem_data_valid),
        .mem_enable       (mem_enable),
        .mem_address      (mem_address),
        .data_write       (data_write),
        .tag_write        (tag_write),
        .offset_write_fsm (offset_write_fsm),
        .fill_data        (fill_data),
        .fill_address     (fill_address),
        .stall            (stall)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs at negedge, check outputs 1ns later, advance the model.
    task automatic do_cycle(input logic miss, input logic [15:0] addr);
        logic        took;
        logic        got8;
        logic        exp_en;
        logic [15:0] rexp;
        logic [18:0] wexp;
        resp_t       resp;
        took = 1'b0;
        got8 = 1'b0;
        @(negedge clk);
        miss_detected = miss;
        miss_address  = addr;
        if (mem_q.size() > 0 && mem_q[0].ready <= cyc) begin
            mem_data_valid = 1'b1;
            mem_data       = mem_q[0].data;
            void'(mem_q.pop_front());
            if (accepting) begin
                exp_wr_q.push_back({3'(words_rx), mem_data});
                words_rx++;
                took = 1'b1;
                if (words_rx == 8) begin
                    accepting = 1'b0;
                    got8      = 1'b1;
                end
            end
        end else begin
            mem_data_valid = 1'b0;
            mem_data       = 16'h0000;
        end
        #1;
        exp_en = (m_state == S_FILL) && (issued < 8);
        chk_val("stall", {31'd0, stall}, {31'd0, (m_state != S_IDLE) || miss});
        chk_val("mem_enable", {31'd0, mem_enable}, {31'd0, exp_en});
        if (mem_enable) begin
            if (exp_rd_q.size() > 0) rexp = exp_rd_q.pop_front();
            else                     rexp = 16'hxxxx;
            chk_val("rd_addr", {16'd0, mem_address}, {16'd0, rexp});
            resp.ready = cyc + LAT;
            if (gap_mode && resp.ready < last_ready + 3) resp.ready = last_ready + 3;
            resp.data  = mem_address ^ 16'hC3A5;
            last_ready = resp.ready;
            mem_q.push_back(resp);
        end
        if (exp_en) issued++;
        chk_val("data_write", {31'd0, data_write}, {31'd0, took});
        if (data_write && took) begin
            wexp = exp_wr_q.pop_front();
            chk_val("wr_word", {13'd0, offset_write_fsm, fill_data}, {13'd0, wexp});
        end
        chk_val("tag_write", {31'd0, tag_write}, {31'd0, m_state == S_TAG});
        chk_val("fill_address", {16'd0, fill_address},
                {16'd0, (m_state == S_IDLE) ? (addr & 16'hFFF0) : m_base});
        if (stall) stall_cnt++;
        case (m_state)
            S_IDLE: begin
                if (miss) begin
                    m_state   = S_FILL;
                    m_base    = addr & 16'hFFF0;
                    for (int k = 0; k < 8; k++) exp_rd_q.push_back(m_base + 16'(2 * k));
                    accepting = 1'b1;
                    words_rx  = 0;
                    issued    = 0;
                end
            end
            S_FILL:  if (got8) m_state = S_TAG;
            default: m_state = S_IDLE;
        endcase
        cyc++;
    endtask

    // One reset cycle with outputs checked while rst is high.
    task automatic do_reset(input logic miss);
        @(negedge clk);
        rst            = 1'b1;
        miss_detected  = miss;
        miss_address   = 16'h5A5A;
        mem_data_valid = 1'b1;
        mem_data       = 16'hDEAD;
        #1;
        chk_val("rst_mem_enable", {31'd0, mem_enable}, 32'd0);
        chk_val("rst_mem_address", {16'd0, mem_address}, 32'd0);
        chk_val("rst_data_write", {31'd0, data_write}, 32'd0);
        chk_val("rst_tag_write", {31'd0, tag_write}, 32'd0);
        chk_val("rst_offset", {29'd0, offset_write_fsm}, 32'd0);
        chk_val("rst_fill_data", {16'd0, fill_data}, 32'd0);
        chk_val("rst_stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        rst            = 1'b0;
        miss_detected  = 1'b0;
        mem_data_valid = 1'b0;
        m_state   = S_IDLE;
        accepting = 1'b0;
        words_rx  = 0;
        issued    = 0;
        exp_rd_q.delete();
        exp_wr_q.delete();
        cyc++;
    endtask

    task automatic run_fill(input logic [15:0] addr, input bit gap, input bit toggle);
        gap_mode   = gap;
        last_ready = -100;
        stall_cnt  = 0;
        do_cycle(1'b1, addr);
        for (int k = 0; k < 80 && m_state != S_IDLE; k++) begin
            do_cycle(toggle ? k[0] : 1'b0, toggle ? 16'hBEEF : addr);
        end
        chk_val("fill_done", m_state, S_IDLE);
        chk_val("stall_cycles", stall_cnt, gap ? 32'd27 : 32'd13);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst            = 1'b1;
        miss_detected  = 1'b0;
        miss_address   = 16'h0000;
        mem_data       = 16'h0000;
        mem_data_valid = 1'b0;
        do_reset(1'b1);
        do_cycle(1'b0, 16'h1236);
        run_fill(16'h1236, 1'b0, 1'b0);
        run_fill(16'hFFF2, 1'b0, 1'b0);
        do_cycle(1'b0, 16'h0000);
        run_fill(16'h1236, 1'b0, 1'b1);
        do_cycle(1'b0, 16'h1236);
        do_cycle(1'b0, 16'h1236);
        run_fill(16'h2468, 1'b1, 1'b0);
        do_cycle(1'b0, 16'h0000);
        gap_mode   = 1'b0;
        last_ready = -100;
        do_cycle(1'b1, 16'h4568);
        for (int k = 0; k < 40 && words_rx < 3; k++) do_cycle(1'b0, 16'h4568);
        chk_val("mid_words", words_rx, 32'd3);
        do_reset(1'b0);
        for (int k = 0; k < 12; k++) do_cycle(1'b0, 16'h4568);
        chk_val("inflight_drained", mem_q.size(), 32'd0);
        chk_val("rd_q_empty", exp_rd_q.size(), 32'd0);
        chk_val("wr_q_empty", exp_wr_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
